// File: rtl/seq_detector_1011.sv
// Serial 1011 pattern detector with bit history and saturating match count.
// Define SEQ_OVERLAP_EN to let the trailing 1 of a match start the next one.
module seq_detector_1011 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D_in,
  input  logic             bit_en,
  input  logic             cnt_clr,
  output logic             det_out,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state_out,
  output logic [3:0]       hist_out
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

`ifdef SEQ_OVERLAP_EN
  localparam state_t DET_NEXT = S1;
`else
  localparam state_t DET_NEXT = S0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;

  assign state_out = state;

  // D_in is only looked at under bit_en, so X while idle never lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S0;
      det_out   <= 1'b0;
      match_cnt <= '0;
      hist_out  <= 4'b0000;
    end else begin
      det_out <= 1'b0;
      if (cnt_clr)
        match_cnt <= '0;
      if (bit_en) begin
        hist_out <= {hist_out[2:0], D_in};
        unique case (state)
          S0: state <= D_in ? S1 : S0;
          S1: state <= D_in ? S1 : S2;
          S2: state <= D_in ? S3 : S0;
          S3: begin
            if (D_in) begin
              det_out <= 1'b1;
              state   <= DET_NEXT;
              if (!cnt_clr && match_cnt != CNT_MAX)
                match_cnt <= match_cnt + CNT_ONE;
            end else begin
              state <= S2;
            end
          end
          default: state <= S0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_1011.sv
// Directed bench for seq_detector_1011, vector table plus corner sequences.
// Expectations follow SEQ_OVERLAP_EN when the build defines it.
module tb_seq_detector_1011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       D_in = 1'b0;
  logic       bit_en = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       det_out, det2;
  logic [7:0] match_cnt;
  logic [1:0] cnt2;
  logic [1:0] state_out, st2;
  logic [3:0] hist_out, hist2;

  int errors = 0;
  int checks = 0;

`ifdef SEQ_OVERLAP_EN
  localparam logic [1:0] SD = 2'b01;
  localparam logic [1:0] S6 = 2'b10;
  localparam logic [1:0] S7 = 2'b11;
  localparam logic       D8 = 1'b1;
  localparam logic [7:0] C8 = 8'd2;
`else
  localparam logic [1:0] SD = 2'b00;
  localparam logic [1:0] S6 = 2'b00;
  localparam logic [1:0] S7 = 2'b01;
  localparam logic       D8 = 1'b0;
  localparam logic [7:0] C8 = 8'd1;
`endif

  seq_detector_1011 #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .D_in(D_in),
    .bit_en(bit_en), .cnt_clr(cnt_clr),
    .det_out(det_out), .match_cnt(match_cnt),
    .state_out(state_out), .hist_out(hist_out)
  );

  seq_detector_1011 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .D_in(D_in),
    .bit_en(bit_en), .cnt_clr(cnt_clr),
    .det_out(det2), .match_cnt(cnt2),
    .state_out(st2), .hist_out(hist2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       r, e, d, c;
    logic       det;
    logic [1:0] st;
    logic [3:0] hist;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string n,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic apply(input logic r, e, d, c);
    rst = r; bit_en = e; D_in = d; cnt_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_1011(input logic clr_last);
    apply(0, 1, 1, 0);
    apply(0, 1, 0, 0);
    apply(0, 1, 1, 0);
    apply(0, 1, 1, clr_last);
  endtask

  initial begin
    //            r  e  d  c   det st     hist     cnt
    tbl.push_back('{1, 0, 0, 0, 0, 2'b00, 4'b0000, 8'd0});
    tbl.push_back('{1, 1, 1, 1, 0, 2'b00, 4'b0000, 8'd0});
    tbl.push_back('{0, 1, 1, 0, 0, 2'b01, 4'b0001, 8'd0});
    tbl.push_back('{0, 1, 0, 0, 0, 2'b10, 4'b0010, 8'd0});
    tbl.push_back('{0, 1, 1, 0, 0, 2'b11, 4'b0101, 8'd0});
    tbl.push_back('{0, 1, 1, 0, 1, SD,    4'b1011, 8'd1});
    tbl.push_back('{0, 1, 0, 0, 0, S6,    4'b0110, 8'd1});
    tbl.push_back('{0, 1, 1, 0, 0, S7,    4'b1101, 8'd1});
    tbl.push_back('{0, 1, 1, 0, D8, 2'b01, 4'b1011, C8});
    tbl.push_back('{1, 1, 1, 0, 0, 2'b00, 4'b0000, 8'd0});
    tbl.push_back('{0, 1, 1, 0, 0, 2'b01, 4'b0001, 8'd0});
    tbl.push_back('{0, 1, 0, 0, 0, 2'b10, 4'b0010, 8'd0});
    tbl.push_back('{0, 0, 1, 0, 0, 2'b10, 4'b0010, 8'd0});
    tbl.push_back('{0, 0, 1, 0, 0, 2'b10, 4'b0010, 8'd0});
    tbl.push_back('{0, 0, 1, 0, 0, 2'b10, 4'b0010, 8'd0});
    tbl.push_back('{0, 1, 1, 0, 0, 2'b11, 4'b0101, 8'd0});
    tbl.push_back('{0, 1, 1, 0, 1, SD,    4'b1011, 8'd1});
    tbl.push_back('{0, 0, 1'bx, 0, 0, SD, 4'b1011, 8'd1});
    tbl.push_back('{0, 0, 1'bx, 1, 0, SD, 4'b1011, 8'd0});
    tbl.push_back('{1, 0, 0, 0, 0, 2'b00, 4'b0000, 8'd0});
    tbl.push_back('{0, 1, 1, 0, 0, 2'b01, 4'b0001, 8'd0});
    tbl.push_back('{0, 1, 0, 0, 0, 2'b10, 4'b0010, 8'd0});
    tbl.push_back('{0, 1, 1, 0, 0, 2'b11, 4'b0101, 8'd0});
    tbl.push_back('{1, 0, 0, 0, 0, 2'b00, 4'b0000, 8'd0});
    tbl.push_back('{0, 1, 1, 0, 0, 2'b01, 4'b0001, 8'd0});

    #1;
    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].c);
      chk($sformatf("row%0d det", i), 16'(det_out), 16'(tbl[i].det));
      chk($sformatf("row%0d state", i), 16'(state_out), 16'(tbl[i].st));
      chk($sformatf("row%0d hist", i), 16'(hist_out), 16'(tbl[i].hist));
      chk($sformatf("row%0d cnt", i), 16'(match_cnt), 16'(tbl[i].cnt));
    end

    // Back-to-back detections: 8-bit counter climbs, 2-bit one saturates.
    apply(1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      send_1011(1'b0);
      chk($sformatf("b2b%0d det", k), 16'(det_out), 16'd1);
      chk($sformatf("b2b%0d cnt8", k), 16'(match_cnt), 16'(k));
      chk($sformatf("b2b%0d cnt2", k), 16'(cnt2), (k < 3) ? 16'(k) : 16'd3);
    end
    apply(0, 1, 0, 0);
    chk("post det low", 16'(det_out), 16'd0);
    chk("post cnt hold", 16'(match_cnt), 16'd5);

    // Clear on the detection edge wins over the increment.
    send_1011(1'b1);
    chk("clr det", 16'(det_out), 16'd1);
    chk("clr cnt", 16'(match_cnt), 16'd0);
    send_1011(1'b0);
    chk("after clr det", 16'(det_out), 16'd1);
    chk("after clr cnt", 16'(match_cnt), 16'd1);
    chk("after clr hist", 16'(hist_out), 16'hB);

    // Reset held several cycles keeps everything at reset values.
    for (int k = 0; k < 3; k++) begin
      apply(1, 1, 1, 0);
      chk($sformatf("hold rst%0d state", k), 16'(state_out), 16'd0);
      chk($sformatf("hold rst%0d cnt", k), 16'(match_cnt), 16'd0);
      chk($sformatf("hold rst%0d hist", k), 16'(hist_out), 16'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
